dmem_responder: RTL and testbench

Multi-cycle data-memory responder that serves load/store requests issued by the pipelined MIPS core's MEM stage. Replaces the single-cycle data memory with a valid/ready request channel, a programmable wait-state count and a one-cycle response pulse, so the core can be stalled on slow memory. Word-addressed storage is held internally. Misaligned and out-of-range accesses are flagged rather than silently aliased.

---
 rtl/mips_pkg.sv | 13 +
 rtl/dmem_array.sv | 26 ++
 rtl/dmem_responder.sv | 142 ++++++++++++++
 tb/tb_dmem_responder.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and widths for the MIPS core's memory-side blocks.
package mips_pkg;

  localparam int WORD_W = 32;
  localparam int WAIT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write, registered read, no reset.
module dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= wdata;
    if (re) rdata_q <= mem_q[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: valid/ready request, programmable wait
// states, one-cycle response pulse with misaligned/out-of-range flagging.
//
// state | meaning
// IDLE  | ready for a request; accept latches req_* and loads the wait counter
// WAIT  | counting down wait states; array access on the edge leaving WAIT
// RESP  | resp_valid pulse for one cycle, then back to IDLE
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW = $clog2(DEPTH);

  dmem_state_t       state_q, state_d;
  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              rd_ok_q, rd_ok_d;

  logic              acc_write;
  logic [WORD_W-1:0] acc_addr;
  logic [WORD_W-1:0] acc_wdata;
  logic              acc_err;
  logic              go_resp;
  logic              arr_we;
  logic              arr_re;
  logic [WORD_W-1:0] arr_rdata;

  // With zero wait states the access happens on the accept edge itself,
  // so the array must see the live request rather than the latches.
  always_comb begin
    acc_write = write_q;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    if (state_q == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
    acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[WORD_W-1:AW+2] != '0);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rd_ok_d = rd_ok_q;
    go_resp = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = WAIT_W'(WAIT_CYCLES);
          if (WAIT_CYCLES == 0) begin
            state_d = RESP;
            go_resp = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= WAIT_W'(1)) begin
          state_d = RESP;
          go_resp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (go_resp) begin
      err_d   = acc_err;
      rd_ok_d = !acc_write && !acc_err;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rd_ok_q <= rd_ok_d;
    end
  end

  assign arr_we = go_resp && acc_write && !acc_err;
  assign arr_re = go_resp && !acc_write && !acc_err;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .addr  (acc_addr[AW+1:2]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  // The array's read register has no reset, so the output is gated here.
  assign req_ready  = (state_q == IDLE) && rst;
  assign resp_valid = (state_q == RESP);
  assign resp_err   = resp_valid && err_q;
  assign resp_rdata = (resp_valid && rd_ok_q) ? arr_rdata : '0;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with 2 wait states,
// one with 0, sharing the request bus and selected by sel.
module tb_dmem_responder;

  localparam int DEPTH = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [31:0] req_wdata = '0;

  logic        valid_a, valid_b;
  logic        rdy_a, rdy_b, rv_a, rv_b, err_a, err_b;
  logic [31:0] rdata_a, rdata_b;
  logic        rdy_cur, rv_cur, err_cur;
  logic [31:0] rdata_cur;

  always #5 clk = ~clk;

  assign valid_a   = req_valid && !sel;
  assign valid_b   = req_valid && sel;
  assign rdy_cur   = sel ? rdy_b : rdy_a;
  assign rv_cur    = sel ? rv_b : rv_a;
  assign err_cur   = sel ? err_b : err_a;
  assign rdata_cur = sel ? rdata_b : rdata_a;

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut_w2 (
    .clk(clk), .rst(rst), .req_valid(valid_a), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy_a),
    .resp_valid(rv_a), .resp_rdata(rdata_a), .resp_err(err_a)
  );

  dmem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .req_valid(valid_b), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(rdy_b),
    .resp_valid(rv_b), .resp_rdata(rdata_b), .resp_err(err_b)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] model [2][DEPTH];
  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc = 0;
  int          issued = 0;
  int          accepts = 0;
  logic        prev_rv = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t it;
    if (rst && rdy_cur && req_valid) accepts++;
    if (rv_cur) begin
      chk("pulse_one_cycle", 32'(prev_rv), 32'd0);
      if (sb_q.size() == 0) begin
        chk("unexpected_resp", 32'd1, 32'd0);
      end else begin
        it = sb_q.pop_front();
        chk("resp_rdata", rdata_cur, it.rdata);
        chk("resp_err", 32'(err_cur), 32'(it.err));
        chk("latency", 32'(cyc - it.acc), 32'(it.lat));
      end
    end
    prev_rv = rv_cur;
  end

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!rdy_cur && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", 32'(rdy_cur), 32'd1);
  endtask

  // Called at the negedge preceding the accept edge.
  task automatic push_exp(input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    logic        err;
    logic [31:0] rd;
    err = (addr[1:0] != 2'b00) || (addr >= 32'(DEPTH * 4));
    rd  = (!wr && !err) ? model[sel][addr[7:2]] : 32'd0;
    if (wr && !err) model[sel][addr[7:2]] = wd;
    sb_q.push_back('{rdata: rd, err: err, acc: cyc, lat: (sel ? 1 : 3)});
    issued++;
  endtask

  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input int tog);
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_valid = 1'b1;
    wait_ready();
    push_exp(wr, addr, wd);
    @(posedge clk);
    #1;
    for (int t = 0; t < tog; t++) begin
      req_addr  = $urandom;
      req_wdata = $urandom;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    chk("drain", 32'(sb_q.size()), 32'd0);
    #1;
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int prev;

    repeat (2) @(negedge clk);
    chk("rst_ready_a", 32'(rdy_a), 32'd0);
    chk("rst_ready_b", 32'(rdy_b), 32'd0);
    chk("rst_valid_a", 32'(rv_a), 32'd0);
    chk("rst_rdata_a", rdata_a, 32'd0);
    chk("rst_err_a", 32'(err_a), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", 32'(rdy_a), 32'd1);
    @(posedge clk);
    #1;

    // Two wait states: store then load back, misaligned and out-of-range cases
    issue(1'b1, 32'h10, 32'hDEAD_BEEF, 0);
    drain();
    issue(1'b0, 32'h10, 32'h0, 0);
    drain();
    issue(1'b1, 32'h12, 32'h1234_5678, 0);
    issue(1'b0, 32'h10, 32'h0, 0);
    issue(1'b0, 32'(DEPTH * 4), 32'h0, 0);
    issue(1'b0, 32'h8000_0010, 32'h0, 0);
    issue(1'b0, 32'h11, 32'h0, 0);
    drain();

    // Request bus churns while the responder is busy
    issue(1'b1, 32'h30, 32'hA5A5_5A5A, 3);
    issue(1'b0, 32'h30, 32'h0, 3);
    issue(1'b1, 32'h34, 32'h0F0F_F0F0, 2);
    issue(1'b0, 32'h34, 32'h0, 1);
    drain();

    // Reset during the wait of a store must drop it
    issue(1'b1, 32'h20, 32'h1111_2222, 0);
    drain();
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h3333_4444;
    req_valid = 1'b1;
    wait_ready();
    issued++;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("midrst_ready", 32'(rdy_a), 32'd0);
    chk("midrst_valid", 32'(rv_a), 32'd0);
    @(negedge clk);
    chk("midrst_ready_2", 32'(rdy_a), 32'd0);
    chk("midrst_valid_2", 32'(rv_a), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("ready_after_midrst", 32'(rdy_a), 32'd1);
    @(posedge clk);
    #1;
    issue(1'b0, 32'h20, 32'h0, 0);
    drain();

    // Zero wait states: fill, then back-to-back loads with req_valid held
    sel = 1'b1;
    for (int k = 0; k < 4; k++) issue(1'b1, 32'(k * 4), 32'hC0DE_0000 + 32'(k), 0);
    drain();
    req_write = 1'b0;
    req_addr  = 32'h0;
    req_valid = 1'b1;
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_ready();
      push_exp(1'b0, req_addr, 32'h0);
      if (k > 0) chk("b2b_spacing", 32'(cyc - prev), 32'd2);
      prev = cyc;
      @(posedge clk);
      #1;
      req_addr = 32'((k + 1) * 4);
    end
    req_valid = 1'b0;
    drain();
    issue(1'b1, 32'h8, 32'h7777_8888, 0);
    issue(1'b0, 32'h8, 32'h0, 0);
    issue(1'b0, 32'h6, 32'h0, 0);
    drain();

    repeat (3) @(posedge clk);
    chk("accept_count", 32'(accepts), 32'(issued));
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
